// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // The step counter needs at least one bit, even when a single digit spans the whole word.
    function automatic int cntWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub; slave is the subtractor's view.
interface serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport slave (
        input  in_valid, a, b, bin, signed_mode, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );

    modport master (
        output in_valid, a, b, bin, signed_mode, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_sub_digit_sub.sv
// Combinational DIGIT-bit subtractor; b_msb is the borrow entering the top bit,
// which the parent needs for the signed overflow rule.
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             b_msb
);
    logic [DIGIT:0] full;

    assign full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, bi};
    assign d    = full[DIGIT-1:0];
    assign bo   = full[DIGIT];

    generate
        if (DIGIT == 1) begin : g_single
            assign b_msb = bi;
        end else begin : g_low
            // Subtracting only the bits below the MSB exposes the borrow into the MSB.
            logic [DIGIT-1:0] low;
            assign low   = {1'b0, a_dig[DIGIT-2:0]} - {1'b0, b_dig[DIGIT-2:0]}
                           - {{(DIGIT-1){1'b0}}, bi};
            assign b_msb = low[DIGIT-1];
        end
    endgenerate
endmodule

// File: rtl/serial_sub.sv
// Digit-serial a - b - bin over WIDTH bits, DIGIT bits per clock, with
// valid/ready handshakes and registered borrow/overflow flags.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cntWidth(N);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("serial_sub: DIGIT must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    state_e           state_q;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             signed_q;
    logic             borrow_q;
    logic             overflow_q;
    logic             inReady_q;
    logic             outValid_q;

    logic [DIGIT-1:0] dDig;
    logic             boDig;
    logic             msbDig;
    logic [WIDTH-1:0] diff_d;

    digit_sub #(.DIGIT(DIGIT)) u_digit (
        .a_dig (aShift_q[DIGIT-1:0]),
        .b_dig (bShift_q[DIGIT-1:0]),
        .bi    (brw_q),
        .d     (dDig),
        .bo    (boDig),
        .b_msb (msbDig)
    );

    // The output register doubles as the result shift register: after N steps
    // every stale bit has been shifted out and the word is complete.
    generate
        if (DIGIT == WIDTH) begin : g_whole
            assign diff_d = dDig;
        end else begin : g_shift
            assign diff_d = {dDig, diff_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            diff_q     <= '0;
            cnt_q      <= '0;
            brw_q      <= 1'b0;
            signed_q   <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        aShift_q  <= bus.a;
                        bShift_q  <= bus.b;
                        signed_q  <= bus.signed_mode;
                        brw_q     <= bus.bin;
                        cnt_q     <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    aShift_q <= aShift_q >> DIGIT;
                    bShift_q <= bShift_q >> DIGIT;
                    diff_q   <= diff_d;
                    brw_q    <= boDig;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        borrow_q   <= boDig;
                        overflow_q <= signed_q ? (msbDig ^ boDig) : boDig;
                        outValid_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: the driver queues hand-computed results,
// a monitor pops them whenever out_valid rises.
module tb_serial_sub #(
    parameter int DIGIT = 4
);
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / DIGIT;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        o;
        int          acc;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycleCnt   = 0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sbQ[$];
    exp_t monE;
    logic prevOv = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    serial_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every rising out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prevOv = 1'b0;
        end else begin
            if ((bus.out_valid === 1'b1) && !prevOv) begin
                if (sbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_result: got out_valid=1 diff=0x%0h, required no result", bus.diff);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput($sformatf("diff#%0d", monE.tag), {16'h0, bus.diff}, {16'h0, monE.d});
                    checkOutput($sformatf("borrow#%0d", monE.tag), {31'h0, bus.borrow}, {31'h0, monE.b});
                    checkOutput($sformatf("overflow#%0d", monE.tag), {31'h0, bus.overflow}, {31'h0, monE.o});
                    checkOutput($sformatf("latency#%0d", monE.tag), cycleCnt - monE.acc, N);
                end
            end
            prevOv = (bus.out_valid === 1'b1);
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 input logic sm, input logic [15:0] eD, input logic eB,
                                 input logic eO, input int tag, input bit expectResult);
        int waitCnt;
        exp_t e;
        waitCnt = 0;
        while ((bus.in_ready !== 1'b1) && (waitCnt < 100)) begin
            @(negedge clk);
            waitCnt++;
        end
        if (bus.in_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL in_ready_timeout#%0d: got in_ready=%b, required 1 within 100 cycles", tag, bus.in_ready);
            return;
        end
        bus.a           = a;
        bus.b           = b;
        bus.bin         = bin;
        bus.signed_mode = sm;
        bus.in_valid    = 1'b1;
        if (expectResult) begin
            e.d   = eD;
            e.b   = eB;
            e.o   = eO;
            e.acc = cycleCnt + 1;
            e.tag = tag;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.a           = ~a;
        bus.b           = ~b;
        bus.bin         = ~bin;
        bus.signed_mode = ~sm;
    endtask

    task automatic waitDrain(input int tag);
        int waitCnt;
        waitCnt = 0;
        while ((sbQ.size() != 0) && (waitCnt < 200)) begin
            @(negedge clk);
            waitCnt++;
        end
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout#%0d: got %0d results pending, required 0", tag, sbQ.size());
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCnt;
        int steps;
        exp_t e;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.bin         = 1'b0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b1;

        @(negedge clk);
        checkOutput("reset_in_ready", {31'h0, bus.in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'h0, bus.out_valid}, 32'd0);
        checkOutput("reset_diff", {16'h0, bus.diff}, 32'd0);
        checkOutput("reset_borrow", {31'h0, bus.borrow}, 32'd0);
        checkOutput("reset_overflow", {31'h0, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors, DIGIT=%0d N=%0d", DIGIT, N);
        applyStimulus(16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 2, 1'b1);
        applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 3, 1'b1);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 4, 1'b1);
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 5, 1'b1);
        applyStimulus(16'h0100, 16'h0001, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 6, 1'b1);
        applyStimulus(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 7, 1'b1);
        applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000E, 1'b0, 1'b0, 8, 1'b1);
        waitDrain(8);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 9, 1'b1);
        waitCnt = 0;
        while ((bus.out_valid !== 1'b1) && (waitCnt < 100)) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("bp_reached_done", {31'h0, bus.out_valid}, 32'd1);
        bus.a           = 16'h1111;
        bus.b           = 16'h2222;
        bus.bin         = 1'b1;
        bus.signed_mode = 1'b1;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_diff", {16'h0, bus.diff}, 32'h9999);
            checkOutput("hold_borrow", {31'h0, bus.borrow}, 32'd0);
            checkOutput("hold_overflow", {31'h0, bus.overflow}, 32'd0);
            checkOutput("hold_out_valid", {31'h0, bus.out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'h0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'h0, bus.in_ready}, 32'd1);
        checkOutput("release_out_valid", {31'h0, bus.out_valid}, 32'd0);
        e.d   = 16'hEEEE;
        e.b   = 1'b1;
        e.o   = 1'b0;
        e.acc = cycleCnt + 1;
        e.tag = 10;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waitDrain(10);

        $display("[TB] reset during RUN");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 11, 1'b0);
        steps = (N > 2) ? 2 : N - 1;
        repeat (steps) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", {31'h0, bus.in_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'h0, bus.out_valid}, 32'd0);
        checkOutput("abort_diff", {16'h0, bus.diff}, 32'd0);
        checkOutput("abort_borrow", {31'h0, bus.borrow}, 32'd0);
        checkOutput("abort_overflow", {31'h0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            checkOutput("abort_no_result", {31'h0, bus.out_valid}, 32'd0);
        end
        applyStimulus(16'h00FF, 16'h000F, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 12, 1'b1);
        waitDrain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
